// File: rtl/pcf8591_i2c_target.sv
// pcf8591_i2c_target: I2C target emulating a PCF8591 ADC/DAC for self-test of the pcf8591 initiator
module pcf8591_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] adc_ch0,
  input  logic [7:0] adc_ch1,
  input  logic [7:0] adc_ch2,
  input  logic [7:0] adc_ch3,
  output logic [7:0] ctrl_byte,
  output logic [7:0] dac_data,
  output logic       dac_valid,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_h_q, sda_h_q;
  logic [7:0] sh_q, sh_d, ctrl_q, ctrl_d, dac_q, dac_d, adc_sel;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic rw_q, rw_d, idx_q, idx_d, valid_q, valid_d, busy_q, busy_d, oe_q, oe_d;
  logic scl, sda, scl_rise, scl_fall, start, stop;
  assign scl = scl_sync_q[SYNC_STAGES-1];
  assign sda = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_h_q;
  assign scl_fall = ~scl & scl_h_q;
  assign start = scl & scl_h_q & sda_h_q & ~sda;
  assign stop = scl & scl_h_q & ~sda_h_q & sda;
  assign adc_sel = ptr_q[1] ? (ptr_q[0] ? adc_ch3 : adc_ch2) : (ptr_q[0] ? adc_ch1 : adc_ch0);
  assign sda_oe = oe_q;
  assign ctrl_byte = ctrl_q;
  assign dac_data = dac_q;
  assign dac_valid = valid_q;
  assign busy = busy_q;
  // Shift the pad inputs into their synchroniser chains
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  end
  // Protocol engine: START/STOP override everything, otherwise advance on SCL edges
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    rw_d = rw_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    ctrl_d = ctrl_q;
    dac_d = dac_q;
    valid_d = 1'b0;
    busy_d = busy_q;
    oe_d = oe_q;
    if (start) begin
      state_d = ADDR;
      cnt_d = 4'd0;
      oe_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, WR_BYTE: begin
          if (scl_rise) begin
            sh_d = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              if (sh_q[7:1] == DEV_ADDR && sh_q[7:1] != 7'd0) begin
                state_d = ADDR_ACK;
                oe_d = 1'b1;
                busy_d = 1'b1;
                rw_d = sh_q[0];
              end else begin
                state_d = WAIT_STOP;
                oe_d = 1'b0;
              end
            end else begin
              state_d = WR_ACK;
              oe_d = 1'b1;
              if (idx_q) begin
                dac_d = sh_q;
                valid_d = 1'b1;
              end else begin
                ctrl_d = sh_q;
                ptr_d = sh_q[1:0];
                idx_d = 1'b1;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            idx_d = 1'b0;
            state_d = rw_q ? RD_BYTE : WR_BYTE;
            sh_d = rw_q ? adc_sel : sh_q;
            oe_d = rw_q ? ~adc_sel[7] : 1'b0;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_BYTE;
            cnt_d = 4'd0;
            oe_d = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            cnt_d = cnt_q + 4'd1;
            sh_d = {sh_q[6:0], 1'b0};
            if (cnt_q == 4'd7) begin
              state_d = RD_ACK;
              oe_d = 1'b0;
              ptr_d = ctrl_q[2] ? ptr_q + 2'd1 : ptr_q;
            end else begin
              oe_d = ~sh_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda) begin
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            state_d = RD_BYTE;
            cnt_d = 4'd0;
            sh_d = adc_sel;
            oe_d = ~adc_sel[7];
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end
  // State and synchroniser flops; reset releases SDA immediately
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q <= 1'b1;
      sda_h_q <= 1'b1;
      sh_q <= 8'h00;
      cnt_q <= 4'd0;
      rw_q <= 1'b0;
      idx_q <= 1'b0;
      ptr_q <= 2'd0;
      ctrl_q <= 8'h00;
      dac_q <= 8'h00;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_h_q <= scl;
      sda_h_q <= sda;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      rw_q <= rw_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      ctrl_q <= ctrl_d;
      dac_q <= dac_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      oe_q <= oe_d;
    end
  end
endmodule

// File: tb/tb_pcf8591_i2c_target.sv
// tb_pcf8591_i2c_target: bit-banged I2C initiator with a transaction-level PCF8591 model
module tb_pcf8591_i2c_target;
  localparam int Q = 200;
  logic sysclk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;
  logic sda_oe, dac_valid, busy;
  logic [7:0] ctrl_byte, dac_data;
  logic [7:0] adc [4];
  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int dv_cnt = 0;
  logic [7:0] m_ctrl = 8'h00;
  logic [7:0] m_dac = 8'h00;
  logic [1:0] m_ptr = 2'd0;

  assign sda_line = sda_m & ~sda_oe;

  pcf8591_i2c_target dut (
    .sysclk(sysclk), .reset(reset), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .adc_ch0(adc[0]), .adc_ch1(adc[1]), .adc_ch2(adc[2]), .adc_ch3(adc[3]),
    .ctrl_byte(ctrl_byte), .dac_data(dac_data), .dac_valid(dac_valid), .busy(busy)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    oe_cnt <= oe_cnt + int'(sda_oe);
    dv_cnt <= dv_cnt + int'(dac_valid);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bit_x(input logic b, output logic l);
    sda_m = b; #Q;
    scl_m = 1'b1; #Q;
    l = sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) bit_x(b[i], l);
    bit_x(1'b1, l);
    ack = ~l;
  endtask

  task automatic rd_byte(output logic [7:0] b);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, l);
      b[i] = l;
    end
  endtask

  task automatic write_frame(input logic [7:0] addr, input logic [7:0] d [4], input int n, output int acks);
    logic a;
    wr_byte(addr, a);
    acks = int'(a);
    for (int i = 0; i < n; i++) begin
      wr_byte(d[i], a);
      acks += int'(a);
    end
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [7:0] d [4], input int n);
    if (addr[7:1] == 7'h48 && !addr[0] && n > 0) begin
      m_ctrl = d[0];
      m_ptr = d[0][1:0];
      if (n > 1) m_dac = d[n-1];
    end
  endtask

  task automatic test_reset;
    foreach (adc[i]) adc[i] = 8'($urandom);
    reset = 1'b1;
    repeat (4) @(negedge sysclk);
    checks += 5;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    if (ctrl_byte !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", ctrl_byte); end
    if (dac_data !== 8'h00) begin errors++; $display("FAIL reset_dac got %h want 00", dac_data); end
    if (dac_valid !== 1'b0) begin errors++; $display("FAIL reset_dac_valid got %b want 0", dac_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic test_write;
    logic [7:0] d [4];
    int acks, dv0, n;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 2 : int'($urandom_range(1, 3));
      foreach (d[i]) d[i] = 8'($urandom);
      if (it == 0) begin d[0] = 8'h44; d[1] = 8'h80; end
      dv0 = dv_cnt;
      i2c_start;
      write_frame(8'h90, d, n, acks);
      model_write(8'h90, d, n);
      checks += 2;
      if (acks !== n + 1) begin errors++; $display("FAIL write_acks it%0d got %0d want %0d", it, acks, n + 1); end
      if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_high it%0d got %b want 1", it, busy); end
      i2c_stop;
      checks += 4;
      if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_low it%0d got %b want 0", it, busy); end
      if (ctrl_byte !== m_ctrl) begin errors++; $display("FAIL write_ctrl it%0d got %h want %h", it, ctrl_byte, m_ctrl); end
      if (dac_data !== m_dac) begin errors++; $display("FAIL write_dac it%0d got %h want %h", it, dac_data, m_dac); end
      if (dv_cnt - dv0 !== n - 1) begin errors++; $display("FAIL write_dac_valid it%0d got %0d want %0d", it, dv_cnt - dv0, n - 1); end
    end
  endtask

  task automatic test_read_rs;
    logic [7:0] d [4];
    logic [7:0] got, exp;
    logic a, l;
    int acks, o;
    for (int it = 0; it < 3; it++) begin
      foreach (adc[i]) adc[i] = 8'($urandom);
      foreach (d[i]) d[i] = 8'($urandom);
      d[0] = (it == 0) ? 8'h02 : (d[0] & 8'hFB);
      if (it == 0) adc[2] = 8'hA5;
      i2c_start;
      write_frame(8'h90, d, 1, acks);
      model_write(8'h90, d, 1);
      i2c_start;
      wr_byte(8'h91, a);
      exp = adc[m_ptr];
      rd_byte(got);
      foreach (adc[i]) adc[i] = 8'h00;
      o = oe_cnt;
      bit_x(1'b1, l);
      for (int i = 0; i < 8; i++) bit_x(1'b1, l);
      i2c_stop;
      checks += 5;
      if (acks !== 2) begin errors++; $display("FAIL read_wr_acks it%0d got %0d want 2", it, acks); end
      if (a !== 1'b1) begin errors++; $display("FAIL read_addr_ack it%0d got %b want 1", it, a); end
      if (got !== exp) begin errors++; $display("FAIL read_data it%0d got %h want %h", it, got, exp); end
      if (oe_cnt !== o) begin errors++; $display("FAIL read_after_nack_oe it%0d got %0d oe cycles want 0", it, oe_cnt - o); end
      if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_low it%0d got %b want 0", it, busy); end
    end
  endtask

  task automatic test_autoinc;
    logic [7:0] d [4];
    logic [7:0] got, exp;
    logic a, l;
    int acks;
    for (int it = 0; it < 3; it++) begin
      foreach (adc[i]) adc[i] = 8'($urandom);
      foreach (d[i]) d[i] = 8'($urandom);
      d[0] = (it == 0) ? 8'h04 : (d[0] | 8'h04);
      if (it == 0) begin adc[0] = 8'h11; adc[1] = 8'h22; adc[2] = 8'h33; adc[3] = 8'h44; end
      i2c_start;
      write_frame(8'h90, d, 1, acks);
      model_write(8'h90, d, 1);
      i2c_start;
      wr_byte(8'h91, a);
      checks += 2;
      if (acks !== 2) begin errors++; $display("FAIL autoinc_wr_acks it%0d got %0d want 2", it, acks); end
      if (a !== 1'b1) begin errors++; $display("FAIL autoinc_addr_ack it%0d got %b want 1", it, a); end
      for (int k = 0; k < 5; k++) begin
        exp = adc[m_ptr];
        for (int b = 7; b >= 4; b--) begin bit_x(1'b1, l); got[b] = l; end
        if (it > 0) foreach (adc[i]) adc[i] = 8'($urandom);
        for (int b = 3; b >= 0; b--) begin bit_x(1'b1, l); got[b] = l; end
        bit_x(k == 4, l);
        m_ptr = m_ptr + 2'd1;
        checks++;
        if (got !== exp) begin errors++; $display("FAIL autoinc_byte it%0d k%0d got %h want %h", it, k, got, exp); end
      end
      i2c_stop;
    end
  endtask

  task automatic test_wrong_addr;
    logic [7:0] d [4];
    logic [7:0] addr;
    int acks, o, dv0;
    for (int it = 0; it < 3; it++) begin
      addr = (it == 0) ? 8'h92 : (it == 1) ? 8'h00 : 8'($urandom);
      if (addr[7:1] == 7'h48) addr = addr ^ 8'h40;
      foreach (d[i]) d[i] = 8'($urandom);
      o = oe_cnt;
      dv0 = dv_cnt;
      i2c_start;
      write_frame(addr, d, 2, acks);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL wrong_busy it%0d got %b want 0", it, busy); end
      i2c_stop;
      checks += 4;
      if (acks !== 0) begin errors++; $display("FAIL wrong_acks it%0d addr %h got %0d want 0", it, addr, acks); end
      if (oe_cnt !== o) begin errors++; $display("FAIL wrong_oe it%0d got %0d oe cycles want 0", it, oe_cnt - o); end
      if (ctrl_byte !== m_ctrl) begin errors++; $display("FAIL wrong_ctrl it%0d got %h want %h", it, ctrl_byte, m_ctrl); end
      if (dv_cnt !== dv0) begin errors++; $display("FAIL wrong_dac_valid it%0d got %0d want 0", it, dv_cnt - dv0); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d [4];
    logic a, l;
    int acks;
    foreach (adc[i]) adc[i] = 8'($urandom);
    adc[1] = adc[1] & 8'hEF;
    foreach (d[i]) d[i] = 8'($urandom);
    d[0] = 8'h01;
    i2c_start;
    write_frame(8'h90, d, 1, acks);
    model_write(8'h90, d, 1);
    i2c_start;
    wr_byte(8'h91, a);
    for (int i = 0; i < 3; i++) bit_x(1'b1, l);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_pre_oe got %b want 1", sda_oe); end
    #3 reset = 1'b1;
    #1;
    checks += 4;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b want 0", sda_oe); end
    if (ctrl_byte !== 8'h00) begin errors++; $display("FAIL rstmid_ctrl got %h want 00", ctrl_byte); end
    if (dac_data !== 8'h00) begin errors++; $display("FAIL rstmid_dac got %h want 00", dac_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    m_ctrl = 8'h00; m_dac = 8'h00; m_ptr = 2'd0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    repeat (4) @(negedge sysclk);
    foreach (d[i]) d[i] = 8'($urandom);
    i2c_start;
    write_frame(8'h90, d, 2, acks);
    model_write(8'h90, d, 2);
    i2c_stop;
    checks += 3;
    if (acks !== 3) begin errors++; $display("FAIL rstmid_fresh_acks got %0d want 3", acks); end
    if (ctrl_byte !== m_ctrl) begin errors++; $display("FAIL rstmid_fresh_ctrl got %h want %h", ctrl_byte, m_ctrl); end
    if (dac_data !== m_dac) begin errors++; $display("FAIL rstmid_fresh_dac got %h want %h", dac_data, m_dac); end
  endtask

  task automatic test_stop_mid;
    logic [7:0] d [4];
    logic l;
    int acks, dv0;
    for (int it = 0; it < 2; it++) begin
      foreach (d[i]) d[i] = 8'($urandom);
      dv0 = dv_cnt;
      i2c_start;
      write_frame(8'h90, d, it, acks);
      model_write(8'h90, d, it);
      for (int i = 0; i < 3; i++) bit_x(1'($urandom), l);
      i2c_stop;
      checks += 5;
      if (acks !== it + 1) begin errors++; $display("FAIL stopmid_acks it%0d got %0d want %0d", it, acks, it + 1); end
      if (ctrl_byte !== m_ctrl) begin errors++; $display("FAIL stopmid_ctrl it%0d got %h want %h", it, ctrl_byte, m_ctrl); end
      if (dac_data !== m_dac) begin errors++; $display("FAIL stopmid_dac it%0d got %h want %h", it, dac_data, m_dac); end
      if (dv_cnt !== dv0) begin errors++; $display("FAIL stopmid_dac_valid it%0d got %0d want 0", it, dv_cnt - dv0); end
      if (busy !== 1'b0) begin errors++; $display("FAIL stopmid_busy it%0d got %b want 0", it, busy); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d [4];
    logic [7:0] got, exp;
    logic a;
    logic l;
    int acks, n, dv0, dv_exp;
    dv0 = dv_cnt;
    dv_exp = 0;
    foreach (adc[i]) adc[i] = 8'($urandom);
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 3));
      i2c_start;
      if (it == 0 || $urandom_range(0, 1) == 0) begin
        foreach (d[i]) d[i] = 8'($urandom);
        write_frame(8'h90, d, n, acks);
        model_write(8'h90, d, n);
        dv_exp += n - 1;
        checks++;
        if (acks !== n + 1) begin errors++; $display("FAIL b2b_wr_acks it%0d got %0d want %0d", it, acks, n + 1); end
      end else begin
        wr_byte(8'h91, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL b2b_rd_addr_ack it%0d got %b want 1", it, a); end
        for (int k = 0; k < n; k++) begin
          exp = adc[m_ptr];
          rd_byte(got);
          bit_x(k == n - 1, l);
          if (m_ctrl[2]) m_ptr = m_ptr + 2'd1;
          checks++;
          if (got !== exp) begin errors++; $display("FAIL b2b_rd_byte it%0d k%0d got %h want %h", it, k, got, exp); end
        end
      end
    end
    i2c_stop;
    checks += 3;
    if (ctrl_byte !== m_ctrl) begin errors++; $display("FAIL b2b_ctrl got %h want %h", ctrl_byte, m_ctrl); end
    if (dac_data !== m_dac) begin errors++; $display("FAIL b2b_dac got %h want %h", dac_data, m_dac); end
    if (dv_cnt - dv0 !== dv_exp) begin errors++; $display("FAIL b2b_dac_valid got %0d want %0d", dv_cnt - dv0, dv_exp); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_rs;
    test_autoinc;
    test_wrong_addr;
    test_reset_mid;
    test_stop_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
